// File: rtl/if_prefetch_stage_if.sv
// Fetch-stage bundle: branch redirect, imem req/gnt/rvalid and decode valid/ready.
// The stage drives the master side, the memory/decode environment the slave side.
interface if_prefetch_stage_if #(
    parameter int WORD_LEN = 32,
    parameter int OFF_LEN  = 16
);
    logic                brTaken;
    logic [WORD_LEN-1:0] brPC;
    logic [OFF_LEN-1:0]  brOffset;
    logic                imemReq;
    logic [WORD_LEN-1:0] imemAddr;
    logic                imemGnt;
    logic                imemRvalid;
    logic [WORD_LEN-1:0] imemRdata;
    logic                outValid;
    logic                outReady;
    logic [WORD_LEN-1:0] outPC;
    logic [WORD_LEN-1:0] outInstr;

    modport master (
        input  brTaken, brPC, brOffset,
        output imemReq, imemAddr,
        input  imemGnt, imemRvalid, imemRdata,
        output outValid, outPC, outInstr,
        input  outReady
    );

    modport slave (
        output brTaken, brPC, brOffset,
        input  imemReq, imemAddr,
        output imemGnt, imemRvalid, imemRdata,
        input  outValid, outPC, outInstr,
        output outReady
    );
endinterface

// File: rtl/if_prefetch_stage.sv
// Decoupled instruction prefetch: sequential imem fetch into a PC-tagged FIFO feeding decode.
// Define IF_PERF_CNT_EN to add saturating perfFetched/perfSquashed/perfStall counters.
module if_prefetch_stage #(
    parameter int                  WORD_LEN  = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC  = '0,
    parameter int                  PC_STEP   = 4,
    parameter int                  OFF_LEN   = 16,
    parameter int                  BR_SHIFT  = 1,
    parameter int                  DEPTH     = 4,
    parameter int                  MAX_OUTST = 2
) (
    input  logic                clk,
    input  logic                rst,
    if_prefetch_stage_if.master bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]         perfFetched,
    output logic [31:0]         perfSquashed,
    output logic [31:0]         perfStall
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]    DEPTH_W = (CNT_W+1)'(DEPTH);
    localparam logic [OUT_W-1:0]  MAXO_C  = OUT_W'(MAX_OUTST);
    localparam logic [WORD_LEN-1:0] STEP_C = WORD_LEN'(PC_STEP);

    logic [WORD_LEN-1:0] fetchPC, retirePC, target;
    logic signed [WORD_LEN-1:0] offExt;
    logic [WORD_LEN-1:0] memPC    [DEPTH];
    logic [WORD_LEN-1:0] memInstr [DEPTH];
    logic [PTR_W-1:0]    wrPtr, rdPtr;
    logic [CNT_W-1:0]    fifoCount;
    logic [CNT_W:0]      inFlight;
    logic [OUT_W-1:0]    outstanding, dropCnt;
    logic                fifoEmpty, fire, push, pop, dropResp;

    assign offExt   = WORD_LEN'($signed(bus.brOffset));
    assign target   = bus.brPC + $unsigned(offExt <<< BR_SHIFT);
    assign fifoEmpty = (fifoCount == '0);
    assign inFlight = {1'b0, fifoCount} + (CNT_W+1)'(outstanding);

    // Reserving FIFO space for every in-flight request is what makes a push always safe.
    assign bus.imemReq  = !rst && !bus.brTaken && (outstanding < MAXO_C) && (inFlight < DEPTH_W);
    assign bus.imemAddr = fetchPC;
    assign fire         = bus.imemReq && bus.imemGnt;

    assign dropResp = bus.imemRvalid && (bus.brTaken || dropCnt != '0);
    assign push     = bus.imemRvalid && !bus.brTaken && dropCnt == '0;
    assign pop      = bus.outValid && bus.outReady && !bus.brTaken;

    assign bus.outValid = !rst && !fifoEmpty;
    assign bus.outPC    = bus.outValid ? memPC[rdPtr]    : '0;
    assign bus.outInstr = bus.outValid ? memInstr[rdPtr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPC     <= RESET_PC;
            retirePC    <= RESET_PC;
            wrPtr       <= '0;
            rdPtr       <= '0;
            fifoCount   <= '0;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            outstanding <= outstanding + OUT_W'(fire) - OUT_W'(bus.imemRvalid);
            if (fire)
                fetchPC <= fetchPC + STEP_C;
            if (bus.brTaken) begin
                fetchPC   <= target;
                retirePC  <= target;
                wrPtr     <= '0;
                rdPtr     <= '0;
                fifoCount <= '0;
                // outstanding already includes any still-pending drops from an earlier redirect
                dropCnt   <= outstanding - OUT_W'(bus.imemRvalid);
            end else begin
                if (dropResp)
                    dropCnt <= dropCnt - OUT_W'(1);
                if (push) begin
                    memPC[wrPtr]    <= retirePC;
                    memInstr[wrPtr] <= bus.imemRdata;
                    wrPtr           <= wrPtr + PTR_W'(1);
                    retirePC        <= retirePC + STEP_C;
                end
                if (pop)
                    rdPtr <= rdPtr + PTR_W'(1);
                fifoCount <= fifoCount + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    noPushOnFull: assert property (@(posedge clk) disable iff (rst)
        !(push && fifoCount == DEPTH_C && !pop));

`ifdef IF_PERF_CNT_EN
    function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [31:0] squashInc;
    assign squashInc = 32'(dropResp) + (bus.brTaken ? 32'(fifoCount) : 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            perfFetched  <= '0;
            perfSquashed <= '0;
            perfStall    <= '0;
        end else begin
            perfFetched  <= satAdd(perfFetched, 32'(pop));
            perfSquashed <= satAdd(perfSquashed, squashInc);
            perfStall    <= satAdd(perfStall, 32'(bus.outValid && !bus.outReady));
        end
    end
`endif
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with a fixed-latency pipelined imem responder.
module tb_if_prefetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   memLat = 1;
    logic [7:0]  vPipe;
    logic [31:0] aPipe [8];

    if_prefetch_stage_if #(.WORD_LEN(32), .OFF_LEN(16)) bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] perfFetched, perfSquashed, perfStall;
    if_prefetch_stage dut (.clk(clk), .rst(rst), .bus(bus),
        .perfFetched(perfFetched), .perfSquashed(perfSquashed), .perfStall(perfStall));
`else
    if_prefetch_stage dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // In-order memory: a granted request returns memLat cycles later, cleared by rst.
    always @(posedge clk) begin
        if (rst) begin
            vPipe <= '0;
        end else begin
            vPipe    <= {vPipe[6:0], bus.imemReq && bus.imemGnt};
            aPipe[0] <= bus.imemAddr;
            for (int i = 1; i < 8; i++) aPipe[i] <= aPipe[i-1];
        end
    end
    assign bus.imemRvalid = vPipe[memLat-1];
    assign bus.imemRdata  = instrOf(aPipe[memLat-1]);

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic applyReset(input int lat);
        memLat = lat; rst = 1'b1; bus.brTaken = 1'b0;
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.brTaken = 0; bus.brPC = '0; bus.brOffset = '0; bus.outReady = 1; bus.imemGnt = 1;
        memLat = 1; rst = 1;
        step(2);
        checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL rst_outValid got=%b exp=0", bus.outValid); end
        checks++; if (bus.imemReq !== 1'b0) begin failures++; $display("FAIL rst_imemReq got=%b exp=0", bus.imemReq); end
        checks++; if (bus.outPC !== 32'h0) begin failures++; $display("FAIL rst_outPC got=%h exp=0", bus.outPC); end
        checks++; if (bus.outInstr !== 32'h0) begin failures++; $display("FAIL rst_outInstr got=%h exp=0", bus.outInstr); end
        rst = 0; #1;
        checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0)
            begin failures++; $display("FAIL first_req got=%b/%h exp=1/0", bus.imemReq, bus.imemAddr); end
        step(1);
        checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL early_valid got=%b exp=0", bus.outValid); end
        step(1);
        checks++; if (bus.outValid !== 1'b1 || bus.outPC !== 32'h0 || bus.outInstr !== instrOf(32'h0))
            begin failures++; $display("FAIL first_out got=%b/%h/%h exp=1/0", bus.outValid, bus.outPC, bus.outInstr); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 3; i++) begin
            step(1);
            checks++; if (bus.outValid !== 1'b1 || bus.outPC !== 32'(4*i) || bus.outInstr !== instrOf(32'(4*i)))
                begin failures++; $display("FAIL stream%0d got=%b/%h exp=1/%h", i, bus.outValid, bus.outPC, 4*i); end
        end
    endtask

    task automatic test_stall();
        step(1);
        checks++; if (bus.outPC !== 32'd16) begin failures++; $display("FAIL stall_head got=%h exp=10", bus.outPC); end
        bus.outReady = 0;
        for (int i = 0; i < 9; i++) begin
            step(1);
            checks++; if (bus.outValid !== 1'b1 || bus.outPC !== 32'd16 || bus.outInstr !== instrOf(32'd16))
                begin failures++; $display("FAIL stall_hold%0d got=%b/%h/%h", i, bus.outValid, bus.outPC, bus.outInstr); end
        end
        checks++; if (bus.imemReq !== 1'b0) begin failures++; $display("FAIL stall_full_req got=%b exp=0", bus.imemReq); end
        bus.outReady = 1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            checks++; if (bus.outValid !== 1'b1 || bus.outPC !== 32'(16 + 4*i))
                begin failures++; $display("FAIL resume%0d got=%b/%h exp=1/%h", i, bus.outValid, bus.outPC, 16 + 4*i); end
        end
    endtask

    task automatic test_redirect_drop();
        int n;
        applyReset(3);
        bus.outReady = 1;
        step(2);
        bus.brTaken = 1; bus.brPC = 32'h20; bus.brOffset = 16'h0010; #1;
        checks++; if (bus.imemReq !== 1'b0) begin failures++; $display("FAIL br_noreq got=%b exp=0", bus.imemReq); end
        step(1);
        bus.brTaken = 0;
        checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL br_flush got=%b exp=0", bus.outValid); end
        n = 0;
        while (bus.outValid !== 1'b1 && n < 20) begin step(1); n++; end
        checks++; if (bus.outValid !== 1'b1 || bus.outPC !== 32'h40 || bus.outInstr !== instrOf(32'h40))
            begin failures++; $display("FAIL br_target got=%b/%h/%h exp=1/40/%h", bus.outValid, bus.outPC, bus.outInstr, instrOf(32'h40)); end
        step(1); n = 0;
        while (bus.outValid !== 1'b1 && n < 20) begin step(1); n++; end
        checks++; if (bus.outValid !== 1'b1 || bus.outPC !== 32'h44 || bus.outInstr !== instrOf(32'h44))
            begin failures++; $display("FAIL br_next got=%b/%h exp=1/44", bus.outValid, bus.outPC); end
    endtask

    task automatic test_wrap();
        applyReset(1);
        bus.outReady = 1;
        step(3);
        bus.brTaken = 1; bus.brPC = 32'h10; bus.brOffset = 16'hFFF8; #1;
        checks++; if (bus.imemReq !== 1'b0) begin failures++; $display("FAIL neg_noreq got=%b exp=0", bus.imemReq); end
        step(1);
        bus.brTaken = 0; #1;
        checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0)
            begin failures++; $display("FAIL neg_req got=%b/%h exp=1/0", bus.imemReq, bus.imemAddr); end
        checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL neg_n1_valid got=%b exp=0", bus.outValid); end
        step(1);
        checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL neg_n2_valid got=%b exp=0", bus.outValid); end
        step(1);
        checks++; if (bus.outValid !== 1'b1 || bus.outPC !== 32'h0 || bus.outInstr !== instrOf(32'h0))
            begin failures++; $display("FAIL neg_n3_out got=%b/%h exp=1/0", bus.outValid, bus.outPC); end
        bus.brTaken = 1; bus.brPC = 32'hFFFF_FFFC; bus.brOffset = 16'h0;
        step(1);
        bus.brTaken = 0; #1;
        checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'hFFFF_FFFC)
            begin failures++; $display("FAIL wrap_req0 got=%b/%h exp=1/fffffffc", bus.imemReq, bus.imemAddr); end
        step(1);
        checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0)
            begin failures++; $display("FAIL wrap_req1 got=%b/%h exp=1/0", bus.imemReq, bus.imemAddr); end
        step(1);
        checks++; if (bus.outValid !== 1'b1 || bus.outPC !== 32'hFFFF_FFFC)
            begin failures++; $display("FAIL wrap_out0 got=%b/%h exp=1/fffffffc", bus.outValid, bus.outPC); end
        step(1);
        checks++; if (bus.outValid !== 1'b1 || bus.outPC !== 32'h0 || bus.outInstr !== instrOf(32'h0))
            begin failures++; $display("FAIL wrap_out1 got=%b/%h exp=1/0", bus.outValid, bus.outPC); end
    endtask

    task automatic test_flush_rvalid();
        applyReset(1);
        bus.outReady = 0;
        step(4);
        checks++; if (bus.outValid !== 1'b1 || bus.outPC !== 32'h0)
            begin failures++; $display("FAIL fr_setup got=%b/%h exp=1/0", bus.outValid, bus.outPC); end
        bus.outReady = 1; bus.brTaken = 1; bus.brPC = 32'h100; bus.brOffset = 16'h0040;
        step(1);
        bus.brTaken = 0; #1;
        checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL fr_empty got=%b exp=0", bus.outValid); end
        checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h180)
            begin failures++; $display("FAIL fr_req got=%b/%h exp=1/180", bus.imemReq, bus.imemAddr); end
`ifdef IF_PERF_CNT_EN
        checks++; if (perfSquashed !== 32'd4) begin failures++; $display("FAIL perf_squash got=%0d exp=4", perfSquashed); end
        checks++; if (perfStall !== 32'd2) begin failures++; $display("FAIL perf_stall got=%0d exp=2", perfStall); end
`endif
        step(1);
        checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL fr_gap got=%b exp=0", bus.outValid); end
        step(1);
        checks++; if (bus.outValid !== 1'b1 || bus.outPC !== 32'h180 || bus.outInstr !== instrOf(32'h180))
            begin failures++; $display("FAIL fr_target got=%b/%h/%h exp=1/180", bus.outValid, bus.outPC, bus.outInstr); end
    endtask

    task automatic test_back_to_back();
        int n;
        applyReset(1);
        bus.outReady = 1;
        step(3);
        bus.brTaken = 1; bus.brPC = 32'h200; bus.brOffset = 16'h0;
        step(1);
        bus.brPC = 32'h300;
        step(1);
        bus.brTaken = 0;
        checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL b2b_flush got=%b exp=0", bus.outValid); end
        n = 0;
        while (bus.outValid !== 1'b1 && n < 20) begin step(1); n++; end
        checks++; if (bus.outValid !== 1'b1 || bus.outPC !== 32'h300 || bus.outInstr !== instrOf(32'h300))
            begin failures++; $display("FAIL b2b_last got=%b/%h exp=1/300", bus.outValid, bus.outPC); end
    endtask

    task automatic test_midreset();
        int n;
        applyReset(3);
        bus.outReady = 0;
        step(6);
        checks++; if (bus.outValid !== 1'b1 || bus.outInstr !== instrOf(32'h0))
            begin failures++; $display("FAIL mr_setup got=%b/%h", bus.outValid, bus.outInstr); end
        rst = 1; #1;
        checks++; if (bus.imemReq !== 1'b0) begin failures++; $display("FAIL mr_req_in_rst got=%b exp=0", bus.imemReq); end
        step(1);
        checks++; if (bus.outValid !== 1'b0 || bus.outPC !== 32'h0 || bus.outInstr !== 32'h0 || bus.imemReq !== 1'b0)
            begin failures++; $display("FAIL mr_outputs got=%b/%h/%h/%b", bus.outValid, bus.outPC, bus.outInstr, bus.imemReq); end
`ifdef IF_PERF_CNT_EN
        checks++; if (perfFetched !== 32'd0 || perfSquashed !== 32'd0 || perfStall !== 32'd0)
            begin failures++; $display("FAIL mr_perf got=%0d/%0d/%0d exp=0", perfFetched, perfSquashed, perfStall); end
`endif
        rst = 0; #1;
        checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0)
            begin failures++; $display("FAIL mr_restart got=%b/%h exp=1/0", bus.imemReq, bus.imemAddr); end
        bus.outReady = 1; n = 0;
        while (bus.outValid !== 1'b1 && n < 20) begin step(1); n++; end
        checks++; if (bus.outValid !== 1'b1 || bus.outPC !== 32'h0 || bus.outInstr !== instrOf(32'h0))
            begin failures++; $display("FAIL mr_first got=%b/%h/%h exp=1/0", bus.outValid, bus.outPC, bus.outInstr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_wrap();
        test_flush_rvalid();
        test_back_to_back();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
